// File: rtl/mc_control_if.sv
// Control/status bundle between the multi-cycle controller
// and the MIPS datapath plus unified memory.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_instr;
  logic       bus_err;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, ext_op,
    output pc_src, pc_write, ir_write, i_or_d,
    output mem_read, mem_write, reg_write,
    output reg_dst, mem_to_reg,
    output illegal_instr, bus_err
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, ext_op,
    input  pc_src, pc_write, ir_write, i_or_d,
    input  mem_read, mem_write, reg_write,
    input  reg_dst, mem_to_reg,
    input  illegal_instr, bus_err
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with memory wait
// handling and bus timeout.
module mc_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  mc_control_if.master bus
);
  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
    S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
  } state_e;

  state_e        state_q, state_d, dec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          ext_q, ext_d;
  logic          sw_q, sw_d;
  logic [2:0]    r_op;
  logic          r_ok;
  logic          waiting;
  logic          tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ext_q   <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ext_q   <= ext_d;
      sw_q    <= sw_d;
    end
  end

  always_comb begin
    r_ok = 1'b1;
    r_op = 3'b010;
    unique case (1'b1)
      bus.funct == F_ADDU: r_op = 3'b010;
      bus.funct == F_SUBU: r_op = 3'b110;
      bus.funct == F_AND:  r_op = 3'b000;
      bus.funct == F_OR:   r_op = 3'b001;
      bus.funct == F_SLT:  r_op = 3'b111;
      default:             r_ok = 1'b0;
    endcase
  end

  // Falling through to FETCH here means the instruction is illegal
  always_comb begin
    dec_d = S_FETCH;
    unique case (1'b1)
      bus.opcode == OP_R:
        dec_d = r_ok ? S_REXEC : S_FETCH;
      bus.opcode == OP_LW,
      bus.opcode == OP_SW:    dec_d = S_MEMADR;
      bus.opcode == OP_ADDIU,
      bus.opcode == OP_ORI:   dec_d = S_IEXEC;
      bus.opcode == OP_BEQ:   dec_d = S_BRANCH;
      bus.opcode == OP_J:     dec_d = S_JUMP;
      default:                dec_d = S_FETCH;
    endcase
  end

  assign waiting = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign tmo = (MEM_TIMEOUT != 0) && waiting &&
               !bus.mem_ready && (cnt_q == LIM);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_d;
      S_MEMADR: state_d = sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (tmo)      state_d = S_FETCH;
      end
      S_MEMWR:  if (bus.mem_ready || tmo) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter restarts whenever a new wait window opens
  assign cnt_d = (state_d != state_q || tmo) ? '0 :
                 bus.mem_ready ? cnt_q : cnt_q + 1'b1;
  assign sw_d  = (state_q == S_DECODE) ?
                 (bus.opcode == OP_SW) : sw_q;
  assign op_d  = (state_q inside {S_REXEC, S_IEXEC}) ?
                 bus.alu_op : op_q;
  assign ext_d = (state_q == S_IEXEC) ? bus.ext_op : ext_q;

  always_comb begin
    bus.alu_op        = 3'b000;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.ext_op        = 1'b0;
    bus.pc_src        = 2'b00;
    bus.pc_write      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.bus_err       = tmo;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 3'b010;
        bus.pc_write  = bus.mem_ready;
        bus.ir_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b     = 2'b11;
        bus.alu_op        = 3'b010;
        bus.ext_op        = 1'b1;
        bus.illegal_instr = (dec_d == S_FETCH);
      end
      S_REXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = r_op;
      end
      S_RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.alu_op    = op_q;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ext_op    = 1'b1;
        bus.alu_op    = 3'b010;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = !tmo;
        bus.i_or_d    = 1'b1;
      end
      S_IEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ext_op    = (bus.opcode != OP_ORI);
        bus.alu_op    = (bus.opcode == OP_ORI) ?
                        3'b001 : 3'b010;
      end
      S_IWB: begin
        bus.reg_write = 1'b1;
        bus.ext_op    = ext_q;
        bus.alu_op    = op_q;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b110;
        bus.pc_src    = 2'b01;
        bus.pc_write  = bus.zero;
      end
      S_JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
